// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter.
// State encoding and port ids used by the arbiter and its winner select.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int MAW    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_H = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU and host requesters.
// DMEM_ARB_RR_EN: round-robin on ties; otherwise CPU has fixed priority.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic i_c_req,
  input  logic i_h_req,
`ifdef DMEM_ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_valid,
  output logic o_win
);

  // A lone request always wins; only a tie consults the policy.
  always_comb begin
    o_valid = i_c_req | i_h_req;
    o_win   = PORT_C;
    if (i_c_req && i_h_req) begin
`ifdef DMEM_ARB_RR_EN
      o_win = ~i_last;
`else
      o_win = PORT_C;
`endif
    end else if (i_h_req) begin
      o_win = PORT_H;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU / host) in front of a 256x32 single-port data RAM.
// DMEM_ARB_RR_EN selects round-robin tie-breaking instead of CPU priority.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [31:0]       h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [MAW-1:0]    m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  state_t              r_state;
  state_t              w_next;
  logic                r_win;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_c_rdata;
  logic [DATA_W-1:0]   r_h_rdata;
  logic                w_valid;
  logic                w_win;
  logic                w_oor;
  logic [DATA_W-1:0]   w_rd;

`ifdef DMEM_ARB_RR_EN
  logic                r_last;
`endif

  dmem_arb_pick u_pick (
    .i_c_req (c_req),
    .i_h_req (h_req),
`ifdef DMEM_ARB_RR_EN
    .i_last  (r_last),
`endif
    .o_valid (w_valid),
    .o_win   (w_win)
  );

  assign w_oor = (r_addr >= 32'(DEPTH));
  assign w_rd  = w_oor ? '0 : m_rdata;

  // State register, request capture in IDLE, read-data hold in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_win     <= PORT_C;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_h_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_valid) begin
        r_win   <= w_win;
        r_we    <= (w_win == PORT_H) ? h_we    : c_we;
        r_addr  <= (w_win == PORT_H) ? h_addr  : c_addr;
        r_wdata <= (w_win == PORT_H) ? h_wdata : c_wdata;
      end
      if (r_state == S_RESP) begin
        if (r_win == PORT_H) r_h_rdata <= w_rd;
        else                 r_c_rdata <= w_rd;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last-winner pointer; reset to H so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_last <= PORT_H;
    else if (r_state == S_ACC) r_last <= r_win;
  end
`endif

  // Next state and all outputs, decoded from the current state.
  always_comb begin
    w_next   = r_state;
    c_gnt    = 1'b0;
    h_gnt    = 1'b0;
    c_rvalid = 1'b0;
    h_rvalid = 1'b0;
    c_rdata  = r_c_rdata;
    h_rdata  = r_h_rdata;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) w_next = S_ACC;
      end
      S_ACC: begin
        c_gnt  = (r_win == PORT_C);
        h_gnt  = (r_win == PORT_H);
        err    = w_oor;
        if (!w_oor) begin
          m_en    = 1'b1;
          m_we    = r_we;
          m_addr  = r_addr[MAW-1:0];
          m_wdata = r_wdata;
        end
        w_next = r_we ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (r_win == PORT_H) begin
          h_rvalid = 1'b1;
          h_rdata  = w_rd;
        end else begin
          c_rvalid = 1'b1;
          c_rdata  = w_rd;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural RAM.
// Tie expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, h_req, h_we;
  logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [31:0] c_rdata, h_rdata;
  logic        m_en, m_we, err;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [31:0] mem [256];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Synchronous single-port RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (m_en && m_we)  mem[m_addr] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr];
  end

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [140:0] outs;
    outs = {c_gnt, h_gnt, c_rvalid, h_rvalid, c_rdata, h_rdata,
            m_en, m_we, m_addr, m_wdata, err};
    n_chk++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL rst_outs got %h want 0", outs);
    end
    rst = 1'b0;
    tick();
    c_req = 1; c_we = 1; c_addr = 7; c_wdata = 32'hDEAD_BEEF;
    tick();
    n_chk++;
    if (c_gnt !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort_gnt got %b want 1", c_gnt);
    end
    #2 rst = 1'b1;
    #1;
    outs = {c_gnt, h_gnt, c_rvalid, h_rvalid, c_rdata, h_rdata,
            m_en, m_we, m_addr, m_wdata, err};
    n_chk++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL abort_outs got %h want 0", outs);
    end
    tick();
    c_req = 0; rst = 1'b0;
    tick();
    n_chk++;
    if ({c_gnt, h_gnt, m_en, c_rvalid} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_rst_idle got %b want 0000",
               {c_gnt, h_gnt, m_en, c_rvalid});
    end
  endtask

  task automatic test_write_read();
    c_req = 1; c_we = 1; c_addr = 5; c_wdata = 32'h1234_5678;
    tick();
    n_chk++;
    if ({c_gnt, m_en, m_we, m_addr, m_wdata} !== {3'b111, 8'd5, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL wr_acc got gnt=%b en=%b we=%b a=%0d d=%h want 1 1 1 5 12345678",
               c_gnt, m_en, m_we, m_addr, m_wdata);
    end
    c_req = 0;
    tick();
    n_chk++;
    if (mem[5] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wr_mem got %h want 12345678", mem[5]);
    end
    c_req = 1; c_we = 0; c_addr = 5;
    tick();
    n_chk++;
    if ({c_gnt, m_en, m_we, c_rvalid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rd_acc got %b want 1100", {c_gnt, m_en, m_we, c_rvalid});
    end
    c_req = 0;
    tick();
    n_chk++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'h1234_5678 || h_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_resp got v=%b d=%h hv=%b want 1 12345678 0",
               c_rvalid, c_rdata, h_rvalid);
    end
    tick();
    n_chk++;
    if (c_rvalid !== 1'b0 || c_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rd_hold got v=%b d=%h want 0 12345678", c_rvalid, c_rdata);
    end
  endtask

  task automatic test_tie();
    logic [3:0] exp_seq;
    logic       got;
    int         k;
`ifdef DMEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c_req = 1; c_we = 0; c_addr = 10;
    h_req = 1; h_we = 0; h_addr = 20;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (k < 8 && !(c_gnt || h_gnt)) begin
        tick();
        k++;
      end
      n_chk++;
      if (!(c_gnt || h_gnt)) begin
        n_fail++; $display("FAIL tie_timeout grant %0d got none want one", g);
        break;
      end
      got = h_gnt;
      n_chk++;
      if (got !== exp_seq[g] || (c_gnt && h_gnt)) begin
        n_fail++;
        $display("FAIL tie_win grant %0d got c=%b h=%b want h=%b",
                 g, c_gnt, h_gnt, exp_seq[g]);
      end
      tick();
      n_chk++;
      if ({c_rvalid, h_rvalid} !== {~got, got}) begin
        n_fail++;
        $display("FAIL tie_rvalid grant %0d got c=%b h=%b want c=%b h=%b",
                 g, c_rvalid, h_rvalid, ~got, got);
      end
      tick();
    end
    c_req = 0; h_req = 0;
    tick();
    tick();
  endtask

  task automatic test_oor();
    h_req = 1; h_we = 0; h_addr = 256;
    tick();
    n_chk++;
    if ({h_gnt, err, m_en, c_gnt} !== 4'b1100) begin
      n_fail++;
      $display("FAIL oor_acc got gnt,err,en,cg=%b want 1100",
               {h_gnt, err, m_en, c_gnt});
    end
    h_req = 0;
    tick();
    n_chk++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_resp got v=%b d=%h e=%b want 1 0 0", h_rvalid, h_rdata, err);
    end
    tick();
    h_req = 1; h_we = 1; h_addr = 255; h_wdata = 32'hCAFE_0255;
    tick();
    n_chk++;
    if ({h_gnt, err, m_en, m_we, m_addr} !== {4'b1011, 8'd255}) begin
      n_fail++;
      $display("FAIL top_wr got g,e,en,we=%b a=%0d want 1011 255",
               {h_gnt, err, m_en, m_we}, m_addr);
    end
    h_we = 0;
    tick();
    tick();
    h_req = 0;
    tick();
    n_chk++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'hCAFE_0255 || c_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL top_rd got v=%b d=%h cv=%b want 1 cafe0255 0",
               h_rvalid, h_rdata, c_rvalid);
    end
    tick();
    c_req = 1; c_we = 1; c_addr = 32'h8000_0005; c_wdata = 32'h5555_AAAA;
    tick();
    n_chk++;
    if ({c_gnt, err, m_en, m_we} !== 4'b1100) begin
      n_fail++;
      $display("FAIL upper_bits got g,e,en,we=%b want 1100", {c_gnt, err, m_en, m_we});
    end
    c_req = 0;
    tick();
    n_chk++;
    if (mem[5] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL upper_nowr got %h want 12345678", mem[5]);
    end
  endtask

  task automatic test_back_to_back();
    int idx, last;
    idx = 0; last = -1;
    c_req = 1; c_we = 1; c_addr = 2; c_wdata = 32'hB0B0_0002;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      tick();
      if (c_gnt) begin
        n_chk++;
        if ((idx == 0 && cyc != 0) || (idx > 0 && cyc - last != 2)) begin
          n_fail++;
          $display("FAIL b2b_space gnt %0d got cycle %0d prev %0d want spacing 2",
                   idx, cyc, last);
        end
        last = cyc;
        idx++;
        if (idx < 3) begin
          c_addr  = 32'(2 + idx);
          c_wdata = 32'hB0B0_0000 | 32'(2 + idx);
        end else begin
          c_req = 0;
        end
      end
    end
    n_chk++;
    if (idx != 3) begin
      n_fail++; $display("FAIL b2b_timeout got %0d grants want 3", idx);
      c_req = 0;
    end
    tick();
    n_chk++;
    if ({mem[2], mem[3], mem[4]} !== {32'hB0B0_0002, 32'hB0B0_0003, 32'hB0B0_0004}) begin
      n_fail++;
      $display("FAIL b2b_mem got %h %h %h want b0b00002 b0b00003 b0b00004",
               mem[2], mem[3], mem[4]);
    end
  endtask

  task automatic test_late();
    c_req = 1; c_we = 1; c_addr = 40; c_wdata = 32'h4040_4040;
    tick();
    h_req = 1; h_we = 0; h_addr = 2; c_req = 0;
    tick();
    n_chk++;
    if (h_gnt !== 1'b0) begin
      n_fail++; $display("FAIL late_wr_early got h_gnt=%b want 0", h_gnt);
    end
    tick();
    n_chk++;
    if (h_gnt !== 1'b1) begin
      n_fail++; $display("FAIL late_wr_gnt got h_gnt=%b want 1", h_gnt);
    end
    h_req = 0;
    tick();
    n_chk++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'hB0B0_0002) begin
      n_fail++;
      $display("FAIL late_wr_rd got v=%b d=%h want 1 b0b00002", h_rvalid, h_rdata);
    end
    tick();
    c_req = 1; c_we = 0; c_addr = 40;
    tick();
    h_req = 1; h_we = 0; h_addr = 3; c_req = 0;
    tick();
    n_chk++;
    if (c_rdata !== 32'h4040_4040 || h_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rd_resp got d=%h hg=%b want 40404040 0", c_rdata, h_gnt);
    end
    tick();
    n_chk++;
    if (h_gnt !== 1'b0) begin
      n_fail++; $display("FAIL late_rd_early got h_gnt=%b want 0", h_gnt);
    end
    tick();
    n_chk++;
    if (h_gnt !== 1'b1) begin
      n_fail++; $display("FAIL late_rd_gnt got h_gnt=%b want 1", h_gnt);
    end
    h_req = 0;
    tick();
    n_chk++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'hB0B0_0003) begin
      n_fail++;
      $display("FAIL late_rd_data got v=%b d=%h want 1 b0b00003", h_rvalid, h_rdata);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    tick();
    tick();
    test_reset();
    test_write_read();
    test_tie();
    test_oor();
    test_back_to_back();
    test_late();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
